// File: rtl/phase_monitor.sv
// phase_monitor: measures how long the upstream phase code dwells in each
// phase and emits one record per completed phase.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset, clears all state and outputs
//   in_valid   in_phase is meaningful this cycle
//   in_phase   phase code from the upstream phase counter
//   clear      synchronous restart to IDLE; err_count is kept
//   out_valid  one-cycle pulse, a dwell record is present
//   out_phase  phase described by the record (held between records)
//   out_dwell  valid cycles spent in out_phase, saturating (held)
//   seq_err    one-cycle pulse, illegal phase transition sampled
//   err_count  illegal transitions since reset, saturating
//   done       sticky, terminal phase reached
module phase_monitor #(
   parameter int unsigned PHASE_W  = 3,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned TERMINAL = 6,
   parameter int unsigned ERR_W    = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [PHASE_W-1:0] in_phase,
   input  logic               clear,
   output logic               out_valid,
   output logic [PHASE_W-1:0] out_phase,
   output logic [CNT_W-1:0]   out_dwell,
   output logic               seq_err,
   output logic [ERR_W-1:0]   err_count,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [PHASE_W-1:0] PH_FIRST = PHASE_W'(1);
   localparam logic [PHASE_W-1:0] PH_TERM  = PHASE_W'(TERMINAL);
   localparam logic [PHASE_W-1:0] PH_ZERO  = '0;
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
   localparam logic [ERR_W-1:0]   ERR_MAX  = '1;

   // Registered state
   state_t             state;
   logic [PHASE_W-1:0] cur_phase;
   logic [CNT_W-1:0]   dwell;

   // Next-state values
   state_t             state_n;
   logic [PHASE_W-1:0] cur_phase_n;
   logic [CNT_W-1:0]   dwell_n;
   logic               out_valid_n;
   logic [PHASE_W-1:0] out_phase_n;
   logic [CNT_W-1:0]   out_dwell_n;
   logic               seq_err_n;
   logic [ERR_W-1:0]   err_count_n;
   logic               done_n;

   // Saturating increments: widen by one bit, test the carry, then truncate
   logic [CNT_W:0]     dwell_sum;
   logic [CNT_W-1:0]   dwell_inc;
   logic [ERR_W:0]     err_sum;
   logic [ERR_W-1:0]   err_inc;
   logic [PHASE_W-1:0] phase_succ;

   always_comb begin
      dwell_sum = {1'b0, dwell} + (CNT_W+1)'(1);
      dwell_inc = dwell_sum[CNT_W] ? CNT_MAX : dwell_sum[CNT_W-1:0];
      err_sum   = {1'b0, err_count} + (ERR_W+1)'(1);
      err_inc   = err_sum[ERR_W] ? ERR_MAX : err_sum[ERR_W-1:0];
      // Expected successor wraps modulo 2^PHASE_W
      phase_succ = cur_phase + PHASE_W'(1);
   end

   // State register and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cur_phase <= '0;
         dwell     <= '0;
         out_valid <= 1'b0;
         out_phase <= '0;
         out_dwell <= '0;
         seq_err   <= 1'b0;
         err_count <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         cur_phase <= cur_phase_n;
         dwell     <= dwell_n;
         out_valid <= out_valid_n;
         out_phase <= out_phase_n;
         out_dwell <= out_dwell_n;
         seq_err   <= seq_err_n;
         err_count <= err_count_n;
         done      <= done_n;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_n     = state;
      cur_phase_n = cur_phase;
      dwell_n     = dwell;
      out_valid_n = 1'b0;
      out_phase_n = out_phase;
      out_dwell_n = out_dwell;
      seq_err_n   = 1'b0;
      err_count_n = err_count;
      done_n      = done;

      if (clear) begin
         // Restart wins over any sample taken in the same cycle
         state_n     = IDLE;
         cur_phase_n = PH_ZERO;
         dwell_n     = '0;
         done_n      = 1'b0;
      end else if (in_valid) begin
         unique case (state)
            IDLE: begin
               if (in_phase == PH_FIRST) begin
                  state_n     = TRACK;
                  cur_phase_n = PH_FIRST;
                  dwell_n     = CNT_ONE;
                  if (PH_FIRST == PH_TERM) begin
                     state_n = DONE;
                     done_n  = 1'b1;
                  end
               end else begin
                  seq_err_n   = 1'b1;
                  err_count_n = err_inc;
               end
            end

            TRACK: begin
               if (in_phase == cur_phase) begin
                  dwell_n = dwell_inc;
               end else begin
                  // Close out the current phase, then resynchronise to
                  // whatever phase arrived, legal or not
                  out_valid_n = 1'b1;
                  out_phase_n = cur_phase;
                  out_dwell_n = dwell;
                  if (in_phase != phase_succ) begin
                     seq_err_n   = 1'b1;
                     err_count_n = err_inc;
                  end
                  cur_phase_n = in_phase;
                  dwell_n     = CNT_ONE;
                  // Terminal dwell is never measured
                  if (in_phase == PH_TERM) begin
                     state_n = DONE;
                     done_n  = 1'b1;
                  end
               end
            end

            DONE: begin
               // Input ignored until clear or reset
            end

            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phase_monitor.sv
module tb_phase_monitor;

   typedef struct {
      logic        v;
      logic        e;
      logic [2:0]  ph;
      logic [15:0] dw;
   } exp_t;

   logic        clock;
   logic        reset;

   // Default-parameter instance
   logic        in_valid;
   logic [2:0]  in_phase;
   logic        clear;
   logic        out_valid;
   logic [2:0]  out_phase;
   logic [15:0] out_dwell;
   logic        seq_err;
   logic [7:0]  err_count;
   logic        done;

   // Narrow-counter instance (CNT_W=4, ERR_W=2)
   logic        s_valid;
   logic [2:0]  s_phase;
   logic        s_clear;
   logic        s_out_valid;
   logic [2:0]  s_out_phase;
   logic [3:0]  s_out_dwell;
   logic        s_seq_err;
   logic [1:0]  s_err_count;
   logic        s_done;

   exp_t q[$];
   exp_t q2[$];
   int   tests;
   int   fails;

   phase_monitor dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_phase  (in_phase),
      .clear     (clear),
      .out_valid (out_valid),
      .out_phase (out_phase),
      .out_dwell (out_dwell),
      .seq_err   (seq_err),
      .err_count (err_count),
      .done      (done)
   );

   phase_monitor #(.PHASE_W(3), .CNT_W(4), .TERMINAL(6), .ERR_W(2)) dut_s (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (s_valid),
      .in_phase  (s_phase),
      .clear     (s_clear),
      .out_valid (s_out_valid),
      .out_phase (s_out_phase),
      .out_dwell (s_out_dwell),
      .seq_err   (s_seq_err),
      .err_count (s_err_count),
      .done      (s_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic exp_rec(input logic [2:0] ph, input logic [15:0] dw, input logic e);
      exp_t x;
      x.v = 1'b1; x.e = e; x.ph = ph; x.dw = dw;
      q.push_back(x);
   endtask

   task automatic exp_err();
      exp_t x;
      x.v = 1'b0; x.e = 1'b1; x.ph = '0; x.dw = '0;
      q.push_back(x);
   endtask

   task automatic exp2_rec(input logic [2:0] ph, input logic [15:0] dw, input logic e);
      exp_t x;
      x.v = 1'b1; x.e = e; x.ph = ph; x.dw = dw;
      q2.push_back(x);
   endtask

   task automatic exp2_err();
      exp_t x;
      x.v = 1'b0; x.e = 1'b1; x.ph = '0; x.dw = '0;
      q2.push_back(x);
   endtask

   // One clock of stimulus on the default instance; returns at the next negedge
   task automatic cyc(input logic v, input logic [2:0] p, input logic c = 1'b0);
      in_valid = v; in_phase = p; clear = c;
      @(negedge clock);
      clear = 1'b0;
   endtask

   task automatic cyc2(input logic v, input logic [2:0] p);
      s_valid = v; s_phase = p; s_clear = 1'b0;
      @(negedge clock);
   endtask

   // Scoreboard check: pop one expectation per presented output event
   task automatic mon_check();
      exp_t x;
      if (out_valid || seq_err) begin
         if (q.size() == 0) begin
            chk("unexpected_event", {30'd0, out_valid, seq_err}, 32'd0);
         end else begin
            x = q.pop_front();
            chk("rec_valid", 32'(out_valid), 32'(x.v));
            chk("rec_seq_err", 32'(seq_err), 32'(x.e));
            if (x.v) begin
               chk("rec_phase", 32'(out_phase), 32'(x.ph));
               chk("rec_dwell", 32'(out_dwell), 32'(x.dw));
            end
         end
      end
      if (s_out_valid || s_seq_err) begin
         if (q2.size() == 0) begin
            chk("s_unexpected_event", {30'd0, s_out_valid, s_seq_err}, 32'd0);
         end else begin
            x = q2.pop_front();
            chk("s_rec_valid", 32'(s_out_valid), 32'(x.v));
            chk("s_rec_seq_err", 32'(s_seq_err), 32'(x.e));
            if (x.v) begin
               chk("s_rec_phase", 32'(s_out_phase), 32'(x.ph));
               chk("s_rec_dwell", 32'(s_out_dwell), 32'(x.dw));
            end
         end
      end
   endtask

   initial begin
      tests = 0; fails = 0;
      reset = 1'b1;
      in_valid = 1'b0; in_phase = '0; clear = 1'b0;
      s_valid = 1'b0; s_phase = '0; s_clear = 1'b0;

      fork
         forever begin
            @(negedge clock);
            mon_check();
         end
      join_none

      repeat (2) @(negedge clock);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_phase", 32'(out_phase), 32'd0);
      chk("rst_out_dwell", 32'(out_dwell), 32'd0);
      chk("rst_seq_err",   32'(seq_err),   32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_done",      32'(done),      32'd0);
      reset = 1'b0;

      // Nominal sequence 1,1,2,3,3,3,4,5,6
      cyc(1, 1); cyc(1, 1);
      exp_rec(1, 2, 0); cyc(1, 2);
      exp_rec(2, 1, 0); cyc(1, 3);
      cyc(1, 3); cyc(1, 3);
      exp_rec(3, 3, 0); cyc(1, 4);
      exp_rec(4, 1, 0); cyc(1, 5);
      chk("nom_done_before", 32'(done), 32'd0);
      exp_rec(5, 1, 0); cyc(1, 6);
      chk("nom_done_with_rec", 32'(done), 32'd1);
      chk("nom_err_count", 32'(err_count), 32'd0);

      // DONE ignores input
      cyc(1, 2); cyc(1, 1); cyc(0, 0);
      chk("done_sticky", 32'(done), 32'd1);

      // Clear in DONE with a valid phase 1 in the same cycle
      cyc(1, 1, 1);
      chk("clr_done_drop", 32'(done), 32'd0);
      chk("clr_err_kept", 32'(err_count), 32'd0);

      // Restart, then gaps in phase 2
      cyc(1, 1);
      exp_rec(1, 1, 0); cyc(1, 2);
      cyc(0, 2); cyc(0, 2); cyc(1, 2); cyc(1, 2);
      exp_rec(2, 3, 0); cyc(1, 3);

      // Illegal jump 1,1,4 then legal 5
      cyc(0, 0, 1);
      cyc(1, 1); cyc(1, 1);
      exp_rec(1, 2, 1); cyc(1, 4);
      chk("jump_err_count", 32'(err_count), 32'd1);
      exp_rec(4, 1, 0); cyc(1, 5);
      chk("jump_then_legal", 32'(err_count), 32'd1);
      chk("jump_not_done", 32'(done), 32'd0);

      // Bad start from IDLE, then normal tracking proves IDLE was kept
      cyc(0, 0, 1);
      exp_err(); cyc(1, 3);
      chk("badstart_err_count", 32'(err_count), 32'd2);
      cyc(1, 1);
      exp_rec(1, 1, 0); cyc(1, 2);

      // Illegal entry straight into the terminal phase
      cyc(0, 0, 1);
      cyc(1, 1);
      exp_rec(1, 1, 1); cyc(1, 6);
      chk("illegal_term_done", 32'(done), 32'd1);
      chk("illegal_term_err", 32'(err_count), 32'd3);

      // Record on every cycle with alternating phases
      cyc(0, 0, 1);
      cyc(1, 1);
      exp_rec(1, 1, 0); cyc(1, 2);
      exp_rec(2, 1, 1); cyc(1, 1);
      exp_rec(1, 1, 0); cyc(1, 2);
      chk("alt_err_count", 32'(err_count), 32'd4);

      // Clear beats a phase change in TRACK; the next 3 is then a bad start
      cyc(1, 3, 1);
      exp_err(); cyc(1, 3);
      chk("clr_prio_err_count", 32'(err_count), 32'd5);

      // Successor wraps: 7 -> 0 is legal
      cyc(0, 0, 1);
      cyc(1, 1);
      exp_rec(1, 1, 1); cyc(1, 7);
      exp_rec(7, 1, 0); cyc(1, 0);
      chk("wrap_err_count", 32'(err_count), 32'd6);

      // Asynchronous reset while a record is on the outputs
      cyc(1, 0);
      exp_rec(0, 2, 1); cyc(1, 2);
      #2 reset = 1'b1;
      #1;
      chk("areset_out_valid", 32'(out_valid), 32'd0);
      chk("areset_out_phase", 32'(out_phase), 32'd0);
      chk("areset_out_dwell", 32'(out_dwell), 32'd0);
      chk("areset_seq_err",   32'(seq_err),   32'd0);
      chk("areset_err_count", 32'(err_count), 32'd0);
      chk("areset_done",      32'(done),      32'd0);
      in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      cyc(1, 1);
      exp_rec(1, 1, 0); cyc(1, 2);
      chk("post_reset_err", 32'(err_count), 32'd0);
      in_valid = 1'b0;

      // Narrow instance: error counter saturation at 3
      for (int i = 0; i < 5; i++) begin
         exp2_err(); cyc2(1, 3);
      end
      chk("s_err_sat", 32'(s_err_count), 32'd3);

      // Narrow instance: dwell saturation at 15
      for (int i = 0; i < 20; i++) cyc2(1, 1);
      exp2_rec(1, 15, 0); cyc2(1, 2);
      s_valid = 1'b0;

      repeat (3) @(negedge clock);
      chk("q_drained", 32'(q.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/phase_monitor.md
# phase_monitor

Downstream consumer of the range-decoded phase counter (the 3-bit phase code that steps 1→6 and holds at 6). It samples the phase stream and measures how many valid cycles each phase lasts. It emits one dwell record per completed phase, flags out-of-order transitions, and raises a sticky `done` when the terminal phase is reached. It sits between the phase generator and the status/CSR logic.

## Interface
- `PHASE_W`, default 3: phase code width.
- `CNT_W`, default 16: dwell counter width.
- `TERMINAL`, default 6: terminal phase code.
- `ERR_W`, default 8: error counter width.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  `in_phase` is meaningful this cycle.
- `in_phase`  in  PHASE_W  phase code from the upstream counter.
- `clear`  in  1  synchronous restart to IDLE (counters kept, see below).
- `out_valid`  out  1  one-cycle pulse: a dwell record is present.
- `out_phase`  out  PHASE_W  phase the record describes.
- `out_dwell`  out  CNT_W  valid cycles spent in `out_phase`, saturating.
- `seq_err`  out  1  one-cycle pulse: illegal transition sampled.
- `err_count`  out  ERR_W  illegal transitions since reset, saturating.
- `done`  out  1  sticky: terminal phase reached.

## Operation
- Reset values: state=IDLE, cur_phase=0, dwell=0. All outputs are 0.
- The machine has three states: IDLE, TRACK, DONE.
- Only cycles with `in_valid`=1 are considered. Cycles with `in_valid`=0 change nothing and do not count dwell.
- IDLE behaviour:
  - `in_phase`==1: go to TRACK with cur_phase=1, dwell=1.
  - Any other value: pulse `seq_err`, increment `err_count`, stay in IDLE.
- TRACK, `in_phase`==cur_phase: dwell increments and saturates at 2^CNT_W−1.
- TRACK, `in_phase`≠cur_phase: emit a record {cur_phase, dwell}. Then:
  - `in_phase`==cur_phase+1 is legal.
  - Any other value is illegal: pulse `seq_err` and increment `err_count`.
  - In both cases, resynchronise with cur_phase=`in_phase` and dwell=1.
- If the new cur_phase equals TERMINAL, go to DONE and set `done`=1. This applies to both legal and illegal entry. The dwell in the terminal phase is not measured or recorded.
- DONE: all input is ignored. No records and no errors are produced. `done` stays 1.
- `clear`=1 in any state:
  - next state is IDLE, cur_phase=0, dwell=0, `done`=0;
  - `err_count` is preserved; only `reset` zeroes it;
  - any `in_valid` in the same cycle is dropped, with no record and no error;
  - `clear` has priority over every other event.
- `err_count` saturates at 2^ERR_W−1. `seq_err` still pulses when the counter is saturated.
- Width rules: dwell arithmetic uses a CNT_W+1 sum truncated after the saturation check. Phase comparison is unsigned PHASE_W bits, and cur_phase+1 wraps modulo 2^PHASE_W.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Record latency: the phase change is sampled on edge N, and `out_valid`, `out_phase` and `out_dwell` are valid for exactly the cycle after edge N.
- `seq_err` is asserted in the same cycle as the record it accompanies.
- `out_phase` and `out_dwell` hold their last record value while `out_valid`=0.
- `done` rises in the same cycle as the record for the phase preceding TERMINAL.
- There is no backpressure. A record may be produced on every valid cycle, for example with alternating phases, and each record is a separate one-cycle pulse.
- `reset` asserted mid-operation forces all outputs to 0 immediately, with no clock needed. The first valid sample is taken on the first rising edge after `reset` deasserts.
- `clear` takes effect on the next edge. Outputs reflect IDLE one cycle later, and `out_valid`/`seq_err` are 0 in that cycle.

## Test plan
- **Nominal sequence:** feed `in_valid`=1 continuously with phases 1,1,2,3,3,3,4,5,6 (one per cycle).
  - Records are (1,2), (2,1), (3,3), (4,1), (5,1).
  - `done`=1 from the cycle of record (5,1) onward.
  - `seq_err` is never asserted and `err_count`=0.
- **Gaps:** phase 2 with `in_valid` pattern 1,0,0,1,1, then phase 3.
  - Record (2,3); idle cycles are not counted.
- **Illegal jump:** phases 1,1,4.
  - Record (1,2) together with a `seq_err` pulse.
  - `err_count`=1; tracking continues in phase 4.
  - A subsequent 5 is legal.
- **Bad start and saturation:**
  - From IDLE, phase 3 gives `seq_err`, state stays IDLE, `err_count`=1.
  - With ERR_W=2, five illegal starts give `err_count`=3 and five `seq_err` pulses.
  - With CNT_W=4, holding phase 1 for 20 cycles then 2 gives record (1,15).
- **Clear and reset:**
  - Assert `clear` in DONE together with `in_valid`/phase 1: `done` drops, no record is produced, `err_count` is kept, and the next phase 1 restarts tracking.
  - Assert `reset` asynchronously mid-phase: all outputs go to 0 before the next edge.
